// File: rtl/te_pkg.sv
// Shared types and defaults for the timing-engine receive-enable generator.
package te_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } te_state_e;

    localparam int TE_CNT_W_DEF = 16;

endpackage

// File: rtl/te_sync.sv
// Generic N-flop synchroniser with synchronous active-high reset.
module te_sync #(
    parameter int STAGES = 2
) (
    input  logic ck,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/te_rx_en_gen.sv
// Turns an rx request edge into a delayed, fixed-length radioRxEnSynced window.
// Optional TE_TRIG_SYNC_EN inserts a SYNC_STAGES synchroniser ahead of edge detect.
module te_rx_en_gen
    import te_pkg::*;
#(
    parameter int CNT_W       = TE_CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             isolateM1M3,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_window,
    output logic             radioRxEnSynced,
    output logic             busy,
    output logic             done,
    output logic             err_overlap
);

    logic trig_eff;

`ifdef TE_TRIG_SYNC_EN
    te_sync #(.STAGES(SYNC_STAGES)) u_trig_sync (
        .ck  (ck),
        .rst (rst),
        .d   (trig),
        .q   (trig_eff)
    );
`else
    assign trig_eff = trig;
`endif

    te_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic             trig_q;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rise;
    logic             stop;

    always_comb begin
        rise    = trig_eff & ~trig_q;
        stop    = abort | isolateM1M3;
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise && !isolateM1M3) begin
                    win_d = cfg_window;
                    if (cfg_window == '0) begin
                        done_d = 1'b1;
                    end else if (cfg_delay == '0) begin
                        state_d = ACTIVE;
                        cnt_d   = cfg_window;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = cfg_delay;
                    end
                end
            end
            DELAY: begin
                err_d = rise & ~isolateM1M3;
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ACTIVE;
                    cnt_d   = win_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACTIVE: begin
                err_d = rise & ~isolateM1M3;
                // Abort beats a normal end landing on the same edge: no done.
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        en_d = (state_d == ACTIVE);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            trig_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            trig_q  <= trig_eff;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Isolation clamps the outputs immediately, without waiting for the FSM.
    assign radioRxEnSynced = en_q & ~isolateM1M3;
    assign done            = done_q & ~isolateM1M3;
    assign err_overlap     = err_q & ~isolateM1M3;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_te_rx_en_gen.sv
// Scoreboard bench for te_rx_en_gen: expected output events queued by stimulus, checked by monitor.
module tb_te_rx_en_gen;

    localparam int CNT_W = 16;
`ifdef TE_TRIG_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef enum int {EV_RISE = 0, EV_FALL = 1, EV_DONE = 2, EV_ERR = 3} ev_e;
    typedef struct {
        ev_e kind;
        int  cyc;
    } ev_t;

    ev_t exp_q[$];

    logic             ck = 1'b0;
    logic             rst = 1'b1;
    logic             iso = 1'b0;
    logic             trig = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] cfg_delay = '0;
    logic [CNT_W-1:0] cfg_window = '0;
    logic             en, busy, done, err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_en = 1'b0;

    te_rx_en_gen #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .ck              (ck),
        .rst             (rst),
        .isolateM1M3     (iso),
        .trig            (trig),
        .abort           (abort),
        .cfg_delay       (cfg_delay),
        .cfg_window      (cfg_window),
        .radioRxEnSynced (en),
        .busy            (busy),
        .done            (done),
        .err_overlap     (err)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic expect_ev(input ev_e k, input int c);
        ev_t e;
        int  i;
        e.kind = k;
        e.cyc  = c;
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= k)))
            i++;
        exp_q.insert(i, e);
    endtask

    task automatic see_ev(input ev_e k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    // Monitor: samples on the falling edge, reports every output event.
    always @(negedge ck) begin
        if (en && !prev_en) see_ev(EV_RISE);
        if (!en && prev_en) see_ev(EV_FALL);
        if (done) see_ev(EV_DONE);
        if (err) see_ev(EV_ERR);
        prev_en <= en;
    end

    task automatic chk(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic trig_pulse();
        trig = 1'b1;
        tick(2);
        trig = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int e1;

        rst = 1'b1;
        tick(3);
        chk("reset_en", en, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        rst = 1'b0;
        tick(2);

        // D=3, W=5; config changed after start must not matter
        cfg_delay = 16'd3; cfg_window = 16'd5;
        e0 = cyc + 1 + LAT;
        expect_ev(EV_RISE, e0 + 3);
        expect_ev(EV_FALL, e0 + 8);
        expect_ev(EV_DONE, e0 + 8);
        trig_pulse();
        wait_until(e0 + 1);
        cfg_delay = 16'd7; cfg_window = 16'd1;
        wait_until(e0 + 4);
        chk("t1_busy_mid", busy, 1'b1);
        wait_until(e0 + 8);
        chk("t1_busy_end", busy, 1'b0);
        wait_until(e0 + 10);

        // D=0, W=1
        cfg_delay = 16'd0; cfg_window = 16'd1;
        e0 = cyc + 1 + LAT;
        expect_ev(EV_RISE, e0);
        expect_ev(EV_FALL, e0 + 1);
        expect_ev(EV_DONE, e0 + 1);
        trig_pulse();
        wait_until(e0 + 3);

        // D=5, W=0: done only, never busy
        cfg_delay = 16'd5; cfg_window = 16'd0;
        e0 = cyc + 1 + LAT;
        expect_ev(EV_DONE, e0);
        trig_pulse();
        wait_until(e0);
        chk("t2_w0_busy", busy, 1'b0);
        wait_until(e0 + 8);
        chk("t2_w0_busy_late", busy, 1'b0);

        // Overlap: second rise at E0+4 during D=2,W=10 window
        cfg_delay = 16'd2; cfg_window = 16'd10;
        e0 = cyc + 1 + LAT;
        expect_ev(EV_RISE, e0 + 2);
        expect_ev(EV_ERR, e0 + 4);
        expect_ev(EV_FALL, e0 + 12);
        expect_ev(EV_DONE, e0 + 12);
        trig_pulse();
        wait_until(e0 + 3 - LAT);
        trig_pulse();
        wait_until(e0 + 14);

        // Abort sampled at E0+7
        cfg_delay = 16'd2; cfg_window = 16'd10;
        e0 = cyc + 1 + LAT;
        expect_ev(EV_RISE, e0 + 2);
        expect_ev(EV_FALL, e0 + 7);
        trig_pulse();
        wait_until(e0 + 6);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);
        chk("t4_abort_busy", busy, 1'b0);
        wait_until(e0 + 14);

        // Isolation mid-window, trig rise while isolated, level held across de-isolation
        cfg_delay = 16'd0; cfg_window = 16'd10;
        e0 = cyc + 1 + LAT;
        expect_ev(EV_RISE, e0);
        expect_ev(EV_FALL, e0 + 3);
        trig_pulse();
        wait_until(e0 + 3);
        iso = 1'b1;
        tick(1);
        chk("t4_iso_busy", busy, 1'b0);
        wait_until(e0 + 5);
        trig = 1'b1;
        tick(4);
        chk("t4_iso_trig_busy", busy, 1'b0);
        wait_until(e0 + 10);
        iso = 1'b0;
        wait_until(e0 + 16);
        chk("t4_deiso_busy", busy, 1'b0);
        chk("t4_deiso_en", en, 1'b0);
        trig = 1'b0;
        tick(4);

        // Reset mid-ACTIVE
        cfg_delay = 16'd1; cfg_window = 16'd10;
        e0 = cyc + 1 + LAT;
        expect_ev(EV_RISE, e0 + 1);
        expect_ev(EV_FALL, e0 + 5);
        trig_pulse();
        wait_until(e0 + 4);
        rst = 1'b1;
        tick(1);
        chk("t5_rst_en", en, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_done", done, 1'b0);
        rst = 1'b0;
        wait_until(e0 + 14);

        // Back-to-back: second rise accepted in the done cycle
        cfg_delay = 16'd1; cfg_window = 16'd3;
        e0 = cyc + 1 + LAT;
        expect_ev(EV_RISE, e0 + 1);
        expect_ev(EV_FALL, e0 + 4);
        expect_ev(EV_DONE, e0 + 4);
        trig_pulse();
        wait_until(e0 + 1);
        cfg_delay = 16'd0; cfg_window = 16'd2;
        wait_until(e0 + 4 - LAT);
        e1 = cyc + 1 + LAT;
        expect_ev(EV_RISE, e1);
        expect_ev(EV_FALL, e1 + 2);
        expect_ev(EV_DONE, e1 + 2);
        trig_pulse();
        wait_until(e1);
        chk("t5_b2b_busy", busy, 1'b1);
        wait_until(e1 + 6);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event: got nothing, required %s at cycle %0d", e.kind.name(), e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
